// File: rtl/router_dest_reader.sv
// router_dest_reader
// Destination-side consumer for one router output port. After the port's
// valid output rises it waits a programmable number of cycles, then drains
// exactly one packet (header, payload, parity) by driving read_enb. It
// checks the trailing parity byte and reports completion, abort or error.
//
// Ports:
//   clk         in   single clock, rising edge
//   resetn      in   asynchronous active-low reset
//   vld_out     in   port FIFO non-empty
//   data_out    in   port FIFO read data (valid the cycle after a read edge)
//   soft_reset  in   port soft reset (FIFO flushed)
//   wait_cycles in   delay before the first read, sampled in IDLE
//   read_enb    out  port read enable (combinational)
//   rx_data     out  captured byte
//   rx_valid    out  one-cycle strobe per captured byte
//   rx_first    out  rx_valid qualifier: header byte
//   rx_last     out  rx_valid qualifier: parity byte
//   pkt_done    out  one-cycle pulse after the parity byte is captured
//   parity_err  out  parity result, valid with pkt_done, held until next header
//   pkt_abort   out  one-cycle pulse when a packet is abandoned by soft_reset
//   busy        out  high whenever the FSM is not in IDLE
module router_dest_reader #(
    parameter int MAX_WAIT = 25
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       vld_out,
    input  logic [7:0] data_out,
    input  logic       soft_reset,
    input  logic [4:0] wait_cycles,
    output logic       read_enb,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_first,
    output logic       rx_last,
    output logic       pkt_done,
    output logic       parity_err,
    output logic       pkt_abort,
    output logic       busy
);

    localparam logic [4:0] MAX_WAIT_L = 5'(MAX_WAIT);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WAIT = 3'd1,
        S_HDR  = 3'd2,
        S_BODY = 3'd3,
        S_DONE = 3'd4
    } state_t;

    function automatic logic [4:0] clamp_wait(input logic [4:0] w);
        logic [4:0] r;
        if (w > MAX_WAIT_L) begin
            r = MAX_WAIT_L;
        end else begin
            r = w;
        end
        return r;
    endfunction

    function automatic logic [7:0] par_update(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

    state_t     state_r, state_n;
    logic [4:0] wcnt_r, wcnt_lim_r;
    logic       hdr_issued_r;
    logic       pend_r;          // a read was issued on the previous edge
    logic [6:0] rd_cnt_r;        // reads issued so far, header included
    logic [5:0] len_r;
    logic [7:0] par_r;
    logic [6:0] total_s;
    logic       abort_s;
    logic       read_enb_s, cap_hdr_s, cap_body_s, cap_last_s;

    logic [7:0] rx_data_r;
    logic       rx_valid_r, rx_first_r, rx_last_r;
    logic       pkt_done_r, parity_err_r, pkt_abort_r, busy_r;

    assign total_s = {1'b0, len_r} + 7'd2;
    assign abort_s = soft_reset && (state_r != S_IDLE);

    // Next-state, read enable and capture decode
    always_comb begin
        state_n    = state_r;
        read_enb_s = 1'b0;
        cap_hdr_s  = 1'b0;
        cap_body_s = 1'b0;
        cap_last_s = 1'b0;
        if (abort_s) begin
            // read_enb stays 0 and any pending capture is dropped
            state_n = S_IDLE;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (vld_out) begin
                        state_n = S_WAIT;
                    end else begin
                        state_n = S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (wcnt_r == wcnt_lim_r) begin
                        state_n = S_HDR;
                    end else begin
                        state_n = S_WAIT;
                    end
                end
                S_HDR: begin
                    read_enb_s = vld_out & ~hdr_issued_r;
                    if (pend_r) begin
                        cap_hdr_s = 1'b1;
                        state_n   = S_BODY;
                    end else begin
                        state_n   = S_HDR;
                    end
                end
                S_BODY: begin
                    read_enb_s = vld_out & (rd_cnt_r < total_s);
                    if (pend_r) begin
                        cap_body_s = 1'b1;
                        // all T reads issued, so this capture is byte T-1
                        if (rd_cnt_r == total_s) begin
                            cap_last_s = 1'b1;
                            state_n    = S_DONE;
                        end else begin
                            state_n    = S_BODY;
                        end
                    end else begin
                        state_n = S_BODY;
                    end
                end
                S_DONE: begin
                    state_n = S_IDLE;
                end
                default: begin
                    state_n = S_IDLE;
                end
            endcase
        end
    end

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // Datapath: wait counter, read tracking, byte capture and status pulses
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wcnt_r       <= 5'd0;
            wcnt_lim_r   <= 5'd0;
            hdr_issued_r <= 1'b0;
            pend_r       <= 1'b0;
            rd_cnt_r     <= 7'd0;
            len_r        <= 6'd0;
            par_r        <= 8'd0;
            rx_data_r    <= 8'd0;
            rx_valid_r   <= 1'b0;
            rx_first_r   <= 1'b0;
            rx_last_r    <= 1'b0;
            pkt_done_r   <= 1'b0;
            parity_err_r <= 1'b0;
            pkt_abort_r  <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            rx_valid_r  <= 1'b0;
            rx_first_r  <= 1'b0;
            rx_last_r   <= 1'b0;
            pkt_done_r  <= 1'b0;
            pkt_abort_r <= 1'b0;
            pend_r      <= read_enb_s;
            busy_r      <= (state_n != S_IDLE);
            if (abort_s) begin
                pkt_abort_r  <= 1'b1;
                hdr_issued_r <= 1'b0;
            end else begin
                case (state_r)
                    S_IDLE: begin
                        hdr_issued_r <= 1'b0;
                        if (vld_out) begin
                            wcnt_lim_r <= clamp_wait(wait_cycles);
                            wcnt_r     <= 5'd0;
                        end
                    end
                    S_WAIT: begin
                        if (vld_out && (wcnt_r != wcnt_lim_r)) begin
                            wcnt_r <= wcnt_r + 5'd1;
                        end
                    end
                    S_HDR: begin
                        if (read_enb_s) begin
                            hdr_issued_r <= 1'b1;
                        end
                        if (cap_hdr_s) begin
                            rx_data_r    <= data_out;
                            rx_valid_r   <= 1'b1;
                            rx_first_r   <= 1'b1;
                            len_r        <= data_out[7:2];
                            par_r        <= data_out;
                            rd_cnt_r     <= 7'd1;
                            parity_err_r <= 1'b0;
                            hdr_issued_r <= 1'b0;
                        end
                    end
                    S_BODY: begin
                        if (read_enb_s) begin
                            rd_cnt_r <= rd_cnt_r + 7'd1;
                        end
                        if (cap_body_s) begin
                            rx_data_r  <= data_out;
                            rx_valid_r <= 1'b1;
                            if (cap_last_s) begin
                                rx_last_r <= 1'b1;
                            end else begin
                                par_r <= par_update(par_r, data_out);
                            end
                        end
                    end
                    S_DONE: begin
                        // rx_data still holds the received parity byte
                        pkt_done_r   <= 1'b1;
                        parity_err_r <= (rx_data_r != par_r);
                    end
                    default: begin
                        hdr_issued_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign read_enb   = read_enb_s;
    assign rx_data    = rx_data_r;
    assign rx_valid   = rx_valid_r;
    assign rx_first   = rx_first_r;
    assign rx_last    = rx_last_r;
    assign pkt_done   = pkt_done_r;
    assign parity_err = parity_err_r;
    assign pkt_abort  = pkt_abort_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_router_dest_reader.sv
`timescale 1ns/1ps
module tb_router_dest_reader;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       vld_out = 1'b0;
    logic [7:0] data_out = 8'h00;
    logic       soft_reset = 1'b0;
    logic [4:0] wait_cycles = 5'd0;
    logic       read_enb;
    logic [7:0] rx_data;
    logic       rx_valid, rx_first, rx_last, pkt_done, parity_err, pkt_abort, busy;

    router_dest_reader #(.MAX_WAIT(25)) dut (
        .clk(clk), .resetn(resetn), .vld_out(vld_out), .data_out(data_out),
        .soft_reset(soft_reset), .wait_cycles(wait_cycles), .read_enb(read_enb),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_first(rx_first), .rx_last(rx_last),
        .pkt_done(pkt_done), .parity_err(parity_err), .pkt_abort(pkt_abort), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] d;
        logic       f;
        logic       l;
    } exp_t;

    exp_t       exp_q[$];
    logic       exp_done[$];
    int         exp_abort = 0;
    logic [7:0] fifo_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int pops = 0, hold_at = -1, hold_cnt = 0, flush_req = 0, flush_ack = 0;
    logic fifo_re;
    int first_re_cyc = -1, re_cnt = 0, done_cyc = -1, last_cyc = -1, rx_cnt = 0;
    int done_seen = 0, abort_seen = 0, re_no_vld = 0, start_cyc = 0;
    exp_t mon_e;
    logic mon_d;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Port FIFO model: pops on an edge where read_enb was high, data valid next cycle
    always @(posedge clk) begin
        fifo_re = read_enb;
        #1;
        if (fifo_re && fifo_q.size() > 0) begin
            data_out = fifo_q.pop_front();
            pops++;
            if (pops == hold_at) hold_cnt = 3;
        end
        if (flush_req != flush_ack) begin
            fifo_q.delete();
            flush_ack = flush_req;
        end
        if (hold_cnt > 0) begin
            vld_out = 1'b0;
            hold_cnt--;
        end else begin
            vld_out = (fifo_q.size() > 0);
        end
    end

    // Scoreboard monitor
    always @(negedge clk) begin
        if (resetn) begin
            if (read_enb) begin
                re_cnt++;
                if (first_re_cyc < 0) first_re_cyc = cyc;
                if (!vld_out) re_no_vld++;
            end
            if (rx_valid) begin
                rx_cnt++;
                if (exp_q.size() == 0) begin
                    chk("rx_unexpected", int'(rx_data), -1);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("rx_byte_first_last", int'({rx_data, rx_first, rx_last}), int'(mon_e));
                end
                if (rx_first) chk("perr_clear_at_hdr", int'(parity_err), 0);
                if (rx_last) last_cyc = cyc;
            end
            if (pkt_done) begin
                done_seen++;
                done_cyc = cyc;
                chk("done_after_last", cyc - last_cyc, 1);
                if (exp_done.size() == 0) begin
                    chk("done_unexpected", 1, 0);
                end else begin
                    mon_d = exp_done.pop_front();
                    chk("parity_err", int'(parity_err), int'(mon_d));
                end
            end
            if (pkt_abort) begin
                abort_seen++;
                chk("abort_expected", (exp_abort > 0) ? 1 : 0, 1);
                if (exp_abort > 0) exp_abort--;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #2;
    endtask

    task automatic load_pkt(input int len, input logic [1:0] addr, input logic corrupt,
                            input logic [4:0] wc);
        logic [5:0] l6;
        logic [7:0] hdr, par, b;
        exp_t e;
        l6 = len[5:0];
        wait_cycles = wc;
        hdr = {l6, addr};
        par = hdr;
        fifo_q.push_back(hdr);
        e = {hdr, 1'b1, 1'b0};
        exp_q.push_back(e);
        for (int i = 0; i < len; i++) begin
            b = 8'h40 + 8'(i * 13);
            par = par ^ b;
            fifo_q.push_back(b);
            e = {b, 1'b0, 1'b0};
            exp_q.push_back(e);
        end
        if (corrupt) par = par ^ 8'h01;
        fifo_q.push_back(par);
        e = {par, 1'b0, 1'b1};
        exp_q.push_back(e);
        exp_done.push_back(corrupt);
        first_re_cyc = -1;
        re_cnt = 0;
        done_cyc = -1;
        rx_cnt = 0;
        start_cyc = cyc + 1;   // vld_out rises right after the next edge
    endtask

    task automatic wait_done();
        int base;
        int k;
        base = done_seen;
        k = 0;
        while (done_seen == base && k < 300) begin
            step(1);
            k++;
        end
        chk("done_timeout", (done_seen != base) ? 1 : 0, 1);
    endtask

    task automatic wait_rx(input int n);
        int k;
        k = 0;
        while (rx_cnt < n && k < 300) begin
            step(1);
            k++;
        end
        chk("rx_wait_timeout", rx_cnt, n);
    endtask

    task automatic check_pkt(input int first_delay, input int t, input int dur);
        chk("first_read_delay", first_re_cyc - start_cyc, first_delay);
        chk("read_count", re_cnt, t);
        chk("rx_count", rx_cnt, t);
        chk("duration", done_cyc - first_re_cyc, dur);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        chk("reset_outputs", int'({read_enb, rx_data, rx_valid, rx_first, rx_last,
                                   pkt_done, parity_err, pkt_abort, busy}), 0);
        step(2);
        resetn = 1'b1;
        step(2);
        chk("idle_busy", int'(busy), 0);

        // wait 3, len 4, steady valid
        load_pkt(4, 2'd1, 1'b0, 5'd3);
        wait_done();
        check_pkt(5, 6, 9);
        step(2);
        chk("busy_after_done", int'(busy), 0);

        // len 0: header 0x02, parity 0x02
        load_pkt(0, 2'd2, 1'b0, 5'd0);
        wait_done();
        check_pkt(2, 2, 5);
        step(2);

        // corrupted parity, len 10
        load_pkt(10, 2'd0, 1'b1, 5'd2);
        wait_done();
        check_pkt(4, 12, 15);
        step(3);
        chk("perr_held", int'(parity_err), 1);

        // valid drops for 3 cycles after the 2nd payload byte
        hold_at = pops + 3;
        load_pkt(4, 2'd3, 1'b0, 5'd0);
        wait_done();
        check_pkt(2, 6, 12);
        step(2);

        // soft reset in BODY after 2 captured bytes
        load_pkt(6, 2'd3, 1'b0, 5'd1);
        wait_rx(2);
        soft_reset = 1'b1;
        flush_req++;
        exp_q.delete();
        exp_done.delete();
        exp_abort = 1;
        #1;
        chk("sr_read_enb", int'(read_enb), 0);
        chk("sr_busy_before", int'(busy), 1);
        @(posedge clk);
        #3;
        soft_reset = 1'b0;
        step(2);
        chk("abort_seen", abort_seen, 1);
        chk("abort_busy", int'(busy), 0);

        // clean packet after abort
        load_pkt(2, 2'd1, 1'b0, 5'd0);
        wait_done();
        check_pkt(2, 4, 7);
        step(2);

        // wait clamp 31 -> 25, then async reset mid-BODY
        load_pkt(8, 2'd2, 1'b0, 5'd31);
        wait_rx(3);
        chk("clamp_first_read", first_re_cyc - start_cyc, 27);
        chk("rst_busy_before", int'(busy), 1);
        resetn = 1'b0;
        #1;
        chk("async_reset_outputs", int'({read_enb, rx_data, rx_valid, rx_first, rx_last,
                                         pkt_done, parity_err, pkt_abort, busy}), 0);
        exp_q.delete();
        exp_done.delete();
        flush_req++;
        @(posedge clk);
        #3;
        resetn = 1'b1;
        step(2);

        // recovery packet
        load_pkt(1, 2'd0, 1'b0, 5'd0);
        wait_done();
        check_pkt(2, 3, 6);
        step(2);

        chk("exp_q_empty", exp_q.size(), 0);
        chk("exp_done_empty", exp_done.size(), 0);
        chk("abort_count", abort_seen, 1);
        chk("read_without_valid", re_no_vld, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
